// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with HI/LO result registers.
// It does one shift-add or restoring shift-subtract step per cycle on operand magnitudes, then applies sign correction.
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] rs_data,
   input  logic [WIDTH-1:0] rt_data,
   input  logic             mthi,
   input  logic             mtlo,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic [1:0]       state_dbg
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } state_t;

   state_t           state;
   logic [CW-1:0]    count;
   logic [1:0]       op_q;
   logic [WIDTH-1:0] rs_q;
   logic [WIDTH-1:0] rt_q;
   logic [WIDTH-1:0] work_hi;
   logic [WIDTH-1:0] work_lo;

   logic             is_div;
   logic             is_signed;
   logic             neg_a;
   logic             neg_b;
   logic             div_zero;
   logic [WIDTH-1:0] mag_b;
   logic             cap_neg_a;
   logic [WIDTH-1:0] cap_mag_a;
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_shift;
   logic [WIDTH-1:0] div_diff;
   logic             div_ge;
   logic [2*WIDTH-1:0] prod;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0] quot_fix;
   logic [WIDTH-1:0] rem_fix;

   // op[1] selects divide, op[0] selects the unsigned variant
   assign is_div    = op_q[1];
   assign is_signed = ~op_q[0];
   assign neg_a     = is_signed & rs_q[WIDTH-1];
   assign neg_b     = is_signed & rt_q[WIDTH-1];
   assign div_zero  = (rt_q == '0);
   assign mag_b     = neg_b ? -rt_q : rt_q;

   assign cap_neg_a = ~op[0] & rs_data[WIDTH-1];
   assign cap_mag_a = cap_neg_a ? -rs_data : rs_data;

   // work_lo holds the multiplier (shifted out LSB first) or the dividend (shifted out MSB first)
   assign mul_sum   = {1'b0, work_hi} + (work_lo[0] ? {1'b0, mag_b} : '0);
   assign div_shift = {work_hi, work_lo[WIDTH-1]};
   assign div_ge    = (div_shift >= {1'b0, mag_b});
   assign div_diff  = div_shift[WIDTH-1:0] - mag_b;

   assign prod      = {work_hi, work_lo};
   assign prod_fix  = (neg_a ^ neg_b) ? -prod : prod;
   assign quot_fix  = (neg_a ^ neg_b) ? -work_lo : work_lo;
   assign rem_fix   = neg_a ? -work_hi : work_hi;

   assign busy      = (state == CALC) || (state == FIX);
   assign state_dbg = state;

   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= IDLE;
         count   <= '0;
         op_q    <= '0;
         rs_q    <= '0;
         rt_q    <= '0;
         work_hi <= '0;
         work_lo <= '0;
         hi      <= '0;
         lo      <= '0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  op_q    <= op;
                  rs_q    <= rs_data;
                  rt_q    <= rt_data;
                  work_hi <= '0;
                  work_lo <= cap_mag_a;
                  count   <= '0;
                  state   <= CALC;
               end else begin
                  if (mthi) hi <= wdata;
                  if (mtlo) lo <= wdata;
               end
            end
            CALC: begin
               if (is_div) begin
                  work_hi <= div_ge ? div_diff : div_shift[WIDTH-1:0];
                  work_lo <= {work_lo[WIDTH-2:0], div_ge};
               end else begin
                  work_hi <= mul_sum[WIDTH:1];
                  work_lo <= {mul_sum[0], work_lo[WIDTH-1:1]};
               end
               count <= count + 1'b1;
               if (count == CW'(WIDTH - 1)) state <= FIX;
            end
            FIX: begin
               if (is_div) begin
                  // divide by zero returns all-ones quotient and the raw dividend
                  if (div_zero) begin
                     lo <= '1;
                     hi <= rs_q;
                  end else begin
                     lo <= quot_fix;
                     hi <= rem_fix;
                  end
               end else begin
                  hi <= prod_fix[2*WIDTH-1:WIDTH];
                  lo <= prod_fix[WIDTH-1:0];
               end
               done  <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed literal cases plus randomized traffic
// compared every cycle against an arithmetic reference model.
module tb_mult_div_unit;

   logic        clock;
   logic        reset;
   logic        start;
   logic [1:0]  op;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic        mthi;
   logic        mtlo;
   logic [31:0] wdata;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;
   logic [1:0]  state_dbg;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   mult_div_unit #(.WIDTH(32)) dut (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .op        (op),
      .rs_data   (rs_data),
      .rt_data   (rt_data),
      .mthi      (mthi),
      .mtlo      (mtlo),
      .wdata     (wdata),
      .busy      (busy),
      .done      (done),
      .hi        (hi),
      .lo        (lo),
      .state_dbg (state_dbg)
   );

   // clock / reset
   initial clock = 1'b0;
   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   // reference arithmetic: returns {hi, lo}
   function automatic logic [63:0] ref_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      p  = '0;
      case (o)
         2'd0: p = sa * sb;
         2'd1: p = {32'd0, a} * {32'd0, b};
         2'd2: begin
            if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
            else begin
               q = sa / sb;
               r = sa % sb;
               p = {r[31:0], q[31:0]};
            end
         end
         default: begin
            if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
            else p = {a % b, a / b};
         end
      endcase
      return p;
   endfunction

   // behavioural model: an accepted op completes 33 edges later
   logic [63:0] exp_q[$];
   int          m_rem   = 0;
   logic        m_valid = 1'b0;
   logic        m_done  = 1'b0;
   logic [31:0] m_hi    = '0;
   logic [31:0] m_lo    = '0;

   always @(posedge clock) begin
      if (reset) begin
         m_valid <= 1'b1;
         m_rem   <= 0;
         m_done  <= 1'b0;
         m_hi    <= '0;
         m_lo    <= '0;
         exp_q.delete();
      end else begin
         m_done <= 1'b0;
         if (m_rem != 0) begin
            m_rem <= m_rem - 1;
            if (m_rem == 1 && exp_q.size() > 0) begin
               m_hi   <= exp_q[0][63:32];
               m_lo   <= exp_q[0][31:0];
               m_done <= 1'b1;
               exp_q.pop_front();
            end
         end else if (start) begin
            exp_q.push_back(ref_op(op, rs_data, rt_data));
            m_rem <= 33;
         end else begin
            if (mthi) m_hi <= wdata;
            if (mtlo) m_lo <= wdata;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // scoreboard compare, every cycle once the model is valid
   always @(negedge clock) begin
      if (m_valid) begin
         check("busy", {31'd0, busy}, {31'd0, (m_rem != 0)});
         check("done", {31'd0, done}, {31'd0, m_done});
         check("hi", hi, m_hi);
         check("lo", lo, m_lo);
         check("state_idle", {31'd0, (state_dbg != 2'd0)}, {31'd0, (m_rem != 0)});
      end
   end

   // drivers: all inputs change 1 time unit after the active edge
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic wait_done(input int t0, output int lat, output int bcnt);
      lat  = -1;
      bcnt = 0;
      for (int i = 0; i < 40 && lat < 0; i++) begin
         @(negedge clock);
         if (busy) bcnt++;
         if (done) lat = cyc - t0;
      end
      if (lat < 0) check("done_timeout", 32'd0, 32'd1);
      step();
   endtask

   task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int bcnt);
      int t0;
      start   = 1'b1;
      op      = o;
      rs_data = a;
      rt_data = b;
      step();
      t0      = cyc;
      start   = 1'b0;
      rs_data = $urandom;
      rt_data = $urandom;
      wait_done(t0, lat, bcnt);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'd0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'd1;
         4: return 32'($urandom_range(0, 100));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int lat, bcnt, t0, dcount;
      reset = 1'b1; start = 1'b0; op = 2'd0; rs_data = '0; rt_data = '0;
      mthi = 1'b0; mtlo = 1'b0; wdata = '0;
      repeat (3) step();
      reset = 1'b0;
      check("rst_hi", hi, 32'd0);
      check("rst_lo", lo, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);

      run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bcnt);
      check("multu_ff_hi", hi, 32'hFFFF_FFFE);
      check("multu_ff_lo", lo, 32'h0000_0001);
      check("multu_latency", 32'(lat), 32'd33);
      check("multu_busy_cycles", 32'(bcnt), 32'd33);

      run_op(2'd0, 32'hFFFF_FFF8, 32'd20, lat, bcnt);
      check("mult_neg_hi", hi, 32'hFFFF_FFFF);
      check("mult_neg_lo", lo, 32'hFFFF_FF60);

      run_op(2'd2, 32'hFFFF_FFEC, 32'd8, lat, bcnt);
      check("div_neg_lo", lo, 32'hFFFF_FFFE);
      check("div_neg_hi", hi, 32'hFFFF_FFFC);

      run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, lat, bcnt);
      check("div_ovf_lo", lo, 32'h8000_0000);
      check("div_ovf_hi", hi, 32'h0000_0000);

      run_op(2'd3, 32'd20, 32'd0, lat, bcnt);
      check("divu_zero_lo", lo, 32'hFFFF_FFFF);
      check("divu_zero_hi", hi, 32'h0000_0014);
      check("divu_zero_latency", 32'(lat), 32'd33);

      // MULTU 8x20 with start and mthi re-pulsed mid-operation
      start = 1'b1; op = 2'd1; rs_data = 32'd8; rt_data = 32'd20;
      step();
      t0 = cyc;
      start = 1'b0;
      repeat (4) step();
      start = 1'b1; mthi = 1'b1; wdata = 32'h1234; rs_data = $urandom; rt_data = $urandom;
      step();
      start = 1'b0; mthi = 1'b0;
      wait_done(t0, lat, bcnt);
      check("busy_ignore_hi", hi, 32'd0);
      check("busy_ignore_lo", lo, 32'd160);
      check("busy_ignore_latency", 32'(lat), 32'd33);
      mtlo = 1'b1; wdata = 32'hABCD;
      step();
      mtlo = 1'b0;
      check("mtlo_lo", lo, 32'h0000_ABCD);
      check("mtlo_hi", hi, 32'd0);

      // reset in the middle of a DIVU
      start = 1'b1; op = 2'd3; rs_data = 32'd1000; rt_data = 32'd7;
      step();
      start = 1'b0;
      repeat (9) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_hi", hi, 32'd0);
      check("abort_lo", lo, 32'd0);
      dcount = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clock);
         if (done) dcount++;
      end
      step();
      check("abort_no_done", 32'(dcount), 32'd0);
      run_op(2'd1, 32'd3, 32'd4, lat, bcnt);
      check("post_reset_lo", lo, 32'd12);
      check("post_reset_hi", hi, 32'd0);

      // randomized traffic, scored by the per-cycle compare against the model
      for (int i = 0; i < 4000; i++) begin
         start   = ($urandom_range(0, 3) == 0);
         op      = 2'($urandom_range(0, 3));
         rs_data = pick();
         rt_data = pick();
         mthi    = ($urandom_range(0, 5) == 0);
         mtlo    = ($urandom_range(0, 5) == 0);
         wdata   = $urandom;
         reset   = ($urandom_range(0, 399) == 0);
         step();
      end
      reset = 1'b0; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
      repeat (40) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
